design02_driver: RTL and testbench

//  Initiator for the start/result/check method interface (start(a,b) action, result(c) value,

---
 rtl/design02_pkg.sv | 36 +++
 rtl/design02_wait_timer.sv | 34 +++
 rtl/design02_driver.sv | 169 ++++++++++++++++
 tb/tb_design02_driver.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/design02_pkg.sv
// design02_pkg: shared types and helpers for the start/result/check driver.
//   state_e     - driver FSM states
//   ops_t       - operand bundle (a, b, c, d) for one transaction
//   derive_ops  - operands for transaction index idx
package design02_pkg;

  localparam int unsigned W = 6;
  localparam int unsigned DefTimeout = 16;
  localparam logic [W-1:0] DefBMask = 6'h2A;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRes,
    StChk,
    StDone
  } state_e;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
  } ops_t;

  // a wraps mod 2^W, so only the low W bits of the index matter.
  function automatic ops_t derive_ops(logic [7:0] idx, logic [W-1:0] mask);
    ops_t o;
    o.a = idx[W-1:0];
    o.b = o.a ^ mask;
    o.c = o.a + o.b;
    o.d = o.b;
    return o;
  endfunction

endpackage

// File: rtl/design02_wait_timer.sv
// design02_wait_timer: counts consecutive not-ready cycles in a wait state.
//   CLK, RST      - clock, synchronous active-high reset
//   i_active      - FSM is in a state that waits on a ready
//   i_not_ready   - the ready for the current state is low
//   i_clear       - FSM changes state this cycle
//   o_expire      - this not-ready cycle is the TIMEOUT-th in a row
module design02_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_active,
  input  logic i_not_ready,
  input  logic i_clear,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_cnt;

  assign o_expire = i_active && i_not_ready && (r_cnt == LastCnt);

  // Expiry forces a state change, so the counter never passes LastCnt.
  always_ff @(posedge CLK) begin
    if (RST || i_clear) begin
      r_cnt <= '0;
    end else if (i_active && i_not_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/design02_driver.sv
// design02_driver: initiator for a start/result/check method interface.
// Runs num_txn transactions (start -> result -> check), honouring each ready, and
// tallies check==result agreement.
//   CLK, RST                  - clock, synchronous active-high reset
//   go, num_txn               - run request from the test controller
//   start_a/b, EN_start, STready
//   result_c, result, RESready
//   check_d, EN_check, check, CHready
//   busy, done, timeout_err   - run status
//   pass_cnt, fail_cnt        - per-run tallies
//   last_result               - result of the most recent transaction
module design02_driver
  import design02_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter logic [W-1:0] B_MASK = DefBMask
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         go,
  input  logic [7:0]   num_txn,
  output logic [W-1:0] start_a,
  output logic [W-1:0] start_b,
  output logic         EN_start,
  input  logic         STready,
  output logic [W-1:0] result_c,
  input  logic [W-1:0] result,
  input  logic         RESready,
  output logic [W-1:0] check_d,
  output logic         EN_check,
  input  logic [W-1:0] check,
  input  logic         CHready,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic [7:0]   pass_cnt,
  output logic [7:0]   fail_cnt,
  output logic [W-1:0] last_result
);

  state_e       r_state, w_state_nxt;
  logic [7:0]   r_num_txn, r_idx, r_pass, r_fail;
  ops_t         r_ops;
  logic [W-1:0] r_res, r_last;
  logic         r_done, r_to;

  logic         w_wait_state, w_not_ready, w_expire, w_state_chg;
  logic [7:0]   w_idx_inc;

  assign w_idx_inc = r_idx + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_not_ready = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (go) w_state_nxt = (num_txn == 8'd0) ? StDone : StStart;
      end
      StStart: begin
        w_not_ready = !STready;
        if (w_expire) w_state_nxt = StDone;
        else if (STready) w_state_nxt = StRes;
      end
      StRes: begin
        w_not_ready = !RESready;
        if (w_expire) w_state_nxt = StDone;
        else if (RESready) w_state_nxt = StChk;
      end
      StChk: begin
        w_not_ready = !CHready;
        if (w_expire) w_state_nxt = StDone;
        else if (CHready) w_state_nxt = (w_idx_inc == r_num_txn) ? StDone : StStart;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_wait_state = (r_state == StStart) || (r_state == StRes) || (r_state == StChk);
  assign w_state_chg  = (w_state_nxt != r_state);

  design02_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .CLK         (CLK),
    .RST         (RST),
    .i_active    (w_wait_state),
    .i_not_ready (w_not_ready),
    .i_clear     (w_state_chg),
    .o_expire    (w_expire)
  );

  // Enables are combinational with the ready but masked by RST so a reset
  // cycle can never issue a method call.
  assign EN_start = (r_state == StStart) && STready && !RST;
  assign EN_check = (r_state == StChk) && CHready && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_num_txn <= '0;
      r_idx     <= '0;
      r_pass    <= '0;
      r_fail    <= '0;
      r_ops     <= '0;
      r_res     <= '0;
      r_last    <= '0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        StIdle, StDone: begin
          if (go) begin
            r_num_txn <= num_txn;
            r_idx     <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_to      <= 1'b0;
            r_done    <= (num_txn == 8'd0);
            r_ops     <= derive_ops(8'd0, B_MASK);
          end
        end
        StStart: begin
          if (w_expire) begin
            r_done <= 1'b1;
            r_to   <= 1'b1;
          end
        end
        StRes: begin
          if (w_expire) begin
            r_done <= 1'b1;
            r_to   <= 1'b1;
          end else if (RESready) begin
            r_res  <= result;
            r_last <= result;
          end
        end
        StChk: begin
          if (w_expire) begin
            r_done <= 1'b1;
            r_to   <= 1'b1;
          end else if (CHready) begin
            if (check == r_res) begin
              if (r_pass != 8'hFF) r_pass <= r_pass + 8'd1;
            end else begin
              if (r_fail != 8'hFF) r_fail <= r_fail + 8'd1;
            end
            r_idx <= w_idx_inc;
            if (w_idx_inc == r_num_txn) r_done <= 1'b1;
            else r_ops <= derive_ops(w_idx_inc, B_MASK);
          end
        end
        default: ;
      endcase
    end
  end

  assign start_a     = r_ops.a;
  assign start_b     = r_ops.b;
  assign result_c    = r_ops.c;
  assign check_d     = r_ops.d;
  assign busy        = w_wait_state;
  assign done        = r_done;
  assign timeout_err = r_to;
  assign pass_cnt    = r_pass;
  assign fail_cnt    = r_fail;
  assign last_result = r_last;

endmodule

// File: tb/tb_design02_driver.sv
// Bench for design02_driver: table of whole-run vectors plus hand sequences for
// late STready and mid-run reset.
module tb_design02_driver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       go = 1'b0;
  logic [7:0] num_txn = 8'd0;
  logic [5:0] start_a, start_b, result_c, check_d, result, check, last_result;
  logic       EN_start, EN_check, STready, RESready, CHready;
  logic       busy, done, timeout_err;
  logic [7:0] pass_cnt, fail_cnt;
  logic       flip_en = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 CLK = ~CLK;

  // Responder: result is a+b, check echoes it (LSB flipped on txn 1 when asked).
  assign result = start_a + start_b;
  assign check  = result ^ {5'd0, (flip_en && (start_a == 6'd1))};

  design02_driver dut (
    .CLK         (CLK),
    .RST         (RST),
    .go          (go),
    .num_txn     (num_txn),
    .start_a     (start_a),
    .start_b     (start_b),
    .EN_start    (EN_start),
    .STready     (STready),
    .result_c    (result_c),
    .result      (result),
    .RESready    (RESready),
    .check_d     (check_d),
    .EN_check    (EN_check),
    .check       (check),
    .CHready     (CHready),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .last_result (last_result)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] n;
    bit         st, rs, ch, flip;
    int         exp_busy, exp_ens, exp_enc;
    int         exp_pass, exp_fail, exp_to, exp_last;
  } vec_t;

  // Pulse go, then count busy cycles and enables until done (bounded).
  task automatic run(input logic [7:0] n, output int busy_c, output int ens,
                     output int enc, output int both, output int fin);
    busy_c = 0; ens = 0; enc = 0; both = 0; fin = 0;
    @(negedge CLK);
    num_txn = n;
    go = 1'b1;
    @(posedge CLK);
    #1 go = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (done && !busy) begin
        fin = 1;
        break;
      end
      if (busy) busy_c++;
      if (EN_start) ens++;
      if (EN_check) enc++;
      if (EN_start && EN_check) both++;
    end
  endtask

  vec_t vecs[7];

  initial begin
    int busy_c, ens, enc, both, fin, bad;
    STready = 1'b1; RESready = 1'b1; CHready = 1'b1;

    //          n    st rs ch fl busy  ens enc pass fail to last
    vecs[0] = '{8'd4,  1, 1, 1, 0, 12,   4,  4,  4,   0,   0, 'h2C};
    vecs[1] = '{8'd0,  1, 1, 1, 0, 0,    0,  0,  0,   0,   0, 'h2C};
    vecs[2] = '{8'd3,  1, 1, 1, 1, 9,    3,  3,  2,   1,   0, 'h2A};
    vecs[3] = '{8'd3,  1, 0, 1, 0, 17,   1,  0,  0,   0,   1, 'h2A};
    vecs[4] = '{8'd2,  1, 1, 0, 0, 18,   1,  0,  0,   0,   1, 'h2A};
    vecs[5] = '{8'd2,  0, 1, 1, 0, 16,   0,  0,  0,   0,   1, 'h2A};
    vecs[6] = '{8'd70, 1, 1, 1, 0, 210, 70, 70, 70,   0,   0, 'h34};

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_en", int'({EN_start, EN_check}), 0);
    chk("rst_cnts", int'({pass_cnt, fail_cnt}), 0);
    chk("rst_ops", int'({start_a, start_b, result_c, check_d, last_result}), 0);
    chk("rst_to", int'(timeout_err), 0);
    RST = 1'b0;

    for (int v = 0; v < 7; v++) begin
      STready  = vecs[v].st;
      RESready = vecs[v].rs;
      CHready  = vecs[v].ch;
      flip_en  = vecs[v].flip;
      run(vecs[v].n, busy_c, ens, enc, both, fin);
      chk($sformatf("v%0d_finished", v), fin, 1);
      chk($sformatf("v%0d_busy", v), busy_c, vecs[v].exp_busy);
      chk($sformatf("v%0d_en_start", v), ens, vecs[v].exp_ens);
      chk($sformatf("v%0d_en_check", v), enc, vecs[v].exp_enc);
      chk($sformatf("v%0d_en_both", v), both, 0);
      chk($sformatf("v%0d_pass", v), int'(pass_cnt), vecs[v].exp_pass);
      chk($sformatf("v%0d_fail", v), int'(fail_cnt), vecs[v].exp_fail);
      chk($sformatf("v%0d_timeout", v), int'(timeout_err), vecs[v].exp_to);
      chk($sformatf("v%0d_last", v), int'(last_result), vecs[v].exp_last);
    end
    flip_en = 1'b0;

    // Late STready: five idle START cycles, then a single EN_start pulse.
    STready = 1'b0; RESready = 1'b1; CHready = 1'b1;
    @(negedge CLK);
    num_txn = 8'd1;
    go = 1'b1;
    @(posedge CLK);
    #1 go = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (EN_start || !busy) bad++;
    end
    chk("late_st_wait", bad, 0);
    @(negedge CLK);
    STready = 1'b1;
    #1;
    chk("late_st_pulse", int'(EN_start), 1);
    ens = 0; fin = 0;
    @(posedge CLK);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (done) begin
        fin = 1;
        break;
      end
      if (EN_start) ens++;
    end
    chk("late_st_finished", fin, 1);
    chk("late_st_extra_en", ens, 0);
    chk("late_st_timeout", int'(timeout_err), 0);
    chk("late_st_pass", int'(pass_cnt), 1);
    chk("late_st_last", int'(last_result), 'h2A);

    // Reset while EN_check is high.
    @(negedge CLK);
    num_txn = 8'd4;
    go = 1'b1;
    @(posedge CLK);
    #1 go = 1'b0;
    fin = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (EN_check) begin
        fin = 1;
        break;
      end
    end
    chk("rst_mid_reached_chk", fin, 1);
    RST = 1'b1;
    #1;
    chk("rst_mid_en_comb", int'(EN_check), 0);
    @(posedge CLK);
    #1;
    chk("rst_mid_en", int'({EN_start, EN_check}), 0);
    chk("rst_mid_status", int'({busy, done, timeout_err}), 0);
    chk("rst_mid_cnts", int'({pass_cnt, fail_cnt}), 0);
    chk("rst_mid_ops", int'({start_a, start_b, result_c, check_d, last_result}), 0);
    @(negedge CLK);
    RST = 1'b0;
    run(8'd2, busy_c, ens, enc, both, fin);
    chk("rerun_finished", fin, 1);
    chk("rerun_busy", busy_c, 6);
    chk("rerun_pass", int'(pass_cnt), 2);
    chk("rerun_last", int'(last_result), 'h2C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
